// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: coin credit, per-item price/stock,
// single-item dispense followed by an explicit change payout.
module vending_ctrl_param #(
  parameter int NUM_ITEMS  = 6,
  parameter int SEL_W      = 3,
  parameter int BASE_PRICE = 3,
  parameter int PRICE_STEP = 1,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    select_item,
  input  logic                cancel,
  input  logic                restock,
  input  logic [SEL_W-1:0]    restock_item,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_item,
  output logic                return_change,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                err_sel,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_e;

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic                 disp_q, disp_d;
  logic [SEL_W-1:0]     item_q, item_d;
  logic                 ret_q, ret_d;
  logic [CREDIT_W-1:0]  amt_q, amt_d;
  logic                 rej_q, rej_d;
  logic                 so_q, so_d;
  logic                 err_q, err_d;

  logic [STOCK_W-1:0]   sel_stock;
  logic [CREDIT_W:0]    sum_c;
  logic [CREDIT_W:0]    price_c;
  int                   price_i;
  logic                 idx_ok;
  logic                 buyable;
  logic                 coin_v;

  // Price kept wide so oversized parameters read as unbuyable, not wrapped
  assign price_i = BASE_PRICE + int'(select_item) * PRICE_STEP;
  assign buyable = (price_i >= 0) && (price_i <= MAX_CREDIT);
  assign price_c = (CREDIT_W+1)'(price_i);
  assign idx_ok  = int'(select_item) < NUM_ITEMS;
  assign coin_v  = coin_in != 2'b00;
  assign sum_c   = {1'b0, credit_q} + (CREDIT_W+1)'(coin_in);

  always_comb begin
    sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (select_item == SEL_W'(i)) sel_stock = stock_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    disp_d   = 1'b0;
    item_d   = '0;
    ret_d    = 1'b0;
    amt_d    = '0;
    rej_d    = 1'b0;
    so_d     = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          rej_d = coin_v;
          if (state_q == COLLECT) begin
            ret_d    = 1'b1;
            amt_d    = credit_q;
            credit_d = '0;
            state_d  = CHANGE;
          end
        end else if (sel_valid) begin
          rej_d = coin_v;
          if (!idx_ok) begin
            err_d = 1'b1;
          end else if (sel_stock == '0) begin
            so_d = 1'b1;
          end else if (!buyable || ({1'b0, credit_q} < price_c)) begin
            err_d = 1'b1;
          end else begin
            disp_d   = 1'b1;
            item_d   = select_item;
            credit_d = credit_q - price_c[CREDIT_W-1:0];
            state_d  = DISPENSE;
            for (int i = 0; i < NUM_ITEMS; i++) begin
              if (select_item == SEL_W'(i)) stock_d[i] = stock_q[i] - 1'b1;
            end
          end
        end else if (coin_v) begin
          if (sum_c <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = sum_c[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        rej_d = coin_v;
        if (credit_q != '0) begin
          ret_d    = 1'b1;
          amt_d    = credit_q;
          credit_d = '0;
          state_d  = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        rej_d   = coin_v;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Restock overrides a same-cycle decrement of the same item
    if (restock) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (restock_item == SEL_W'(i)) stock_d[i] = STOCK_W'(STOCK_INIT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      disp_q   <= 1'b0;
      item_q   <= '0;
      ret_q    <= 1'b0;
      amt_q    <= '0;
      rej_q    <= 1'b0;
      so_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
      disp_q   <= disp_d;
      item_q   <= item_d;
      ret_q    <= ret_d;
      amt_q    <= amt_d;
      rej_q    <= rej_d;
      so_q     <= so_d;
      err_q    <= err_d;
    end
  end

  assign dispense      = disp_q;
  assign dispense_item = item_q;
  assign return_change = ret_q;
  assign change_amt    = amt_q;
  assign credit        = credit_q;
  assign coin_reject   = rej_q;
  assign sold_out      = so_q;
  assign err_sel       = err_q;
  assign busy          = (state_q == DISPENSE) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: directed plan plus random traffic
// compared against a credit/stock reference model.
module tb_vending_ctrl_param;

  localparam int NUM   = 6;
  localparam int SW    = 3;
  localparam int BASE  = 3;
  localparam int STEP  = 1;
  localparam int MAXC  = 15;
  localparam int CW    = 4;
  localparam int STW   = 4;
  localparam int SINIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    coin_in;
  logic          sel_valid;
  logic [SW-1:0] select_item;
  logic          cancel;
  logic          restock;
  logic [SW-1:0] restock_item;
  logic          dispense;
  logic [SW-1:0] dispense_item;
  logic          return_change;
  logic [CW-1:0] change_amt;
  logic [CW-1:0] credit;
  logic          coin_reject;
  logic          sold_out;
  logic          err_sel;
  logic          busy;

  always #5 clk = ~clk;

  vending_ctrl_param #(
    .NUM_ITEMS(NUM), .SEL_W(SW), .BASE_PRICE(BASE), .PRICE_STEP(STEP),
    .MAX_CREDIT(MAXC), .CREDIT_W(CW), .STOCK_W(STW), .STOCK_INIT(SINIT)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid),
    .select_item(select_item), .cancel(cancel), .restock(restock),
    .restock_item(restock_item), .dispense(dispense),
    .dispense_item(dispense_item), .return_change(return_change),
    .change_amt(change_amt), .credit(credit), .coin_reject(coin_reject),
    .sold_out(sold_out), .err_sel(err_sel), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference: credit, stock per item, and phase
  // (0 = taking coins, 1 = item releasing, 2 = change paying)
  int m_cr;
  int m_stk [NUM];
  int m_ph;
  bit e_disp, e_ret, e_rej, e_so, e_err;
  int e_item, e_amt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cr = 0;
    m_ph = 0;
    for (int i = 0; i < NUM; i++) m_stk[i] = SINIT;
  endtask

  task automatic model(input int c, input bit s, input int idx,
                       input bit cn, input bit r, input int ri);
    int p;
    e_disp = 0; e_ret = 0; e_rej = 0; e_so = 0; e_err = 0;
    e_item = 0; e_amt = 0;
    if (m_ph == 1) begin
      e_rej = (c != 0);
      if (m_cr > 0) begin
        e_ret = 1; e_amt = m_cr; m_cr = 0; m_ph = 2;
      end else m_ph = 0;
    end else if (m_ph == 2) begin
      e_rej = (c != 0);
      m_ph = 0;
    end else if (cn) begin
      e_rej = (c != 0);
      if (m_cr > 0) begin
        e_ret = 1; e_amt = m_cr; m_cr = 0; m_ph = 2;
      end
    end else if (s) begin
      e_rej = (c != 0);
      p = BASE + idx * STEP;
      if (idx >= NUM) e_err = 1;
      else if (m_stk[idx] == 0) e_so = 1;
      else if (p > MAXC || m_cr < p) e_err = 1;
      else begin
        e_disp = 1; e_item = idx;
        m_cr -= p; m_stk[idx]--; m_ph = 1;
      end
    end else if (c != 0) begin
      if (m_cr + c <= MAXC) m_cr += c;
      else e_rej = 1;
    end
    if (r && ri < NUM) m_stk[ri] = SINIT;
  endtask

  task automatic check_outs();
    chk("dispense", dispense, e_disp);
    if (e_disp) chk("dispense_item", dispense_item, e_item);
    chk("return_change", return_change, e_ret);
    if (e_ret) chk("change_amt", change_amt, e_amt);
    chk("credit", credit, m_cr);
    chk("coin_reject", coin_reject, e_rej);
    chk("sold_out", sold_out, e_so);
    chk("err_sel", err_sel, e_err);
    chk("busy", busy, m_ph != 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dispense"}, dispense, 0);
    chk({tag, "_item"}, dispense_item, 0);
    chk({tag, "_ret"}, return_change, 0);
    chk({tag, "_amt"}, change_amt, 0);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_rej"}, coin_reject, 0);
    chk({tag, "_so"}, sold_out, 0);
    chk({tag, "_err"}, err_sel, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic cyc(input int c, input bit s, input int idx,
                     input bit cn, input bit r, input int ri);
    @(negedge clk);
    coin_in      = 2'(c);
    sel_valid    = s;
    select_item  = SW'(idx);
    cancel       = cn;
    restock      = r;
    restock_item = SW'(ri);
    @(posedge clk);
    model(c, s, idx, cn, r, ri);
    #1 check_outs();
  endtask

  task automatic coin(input int c);
    cyc(c, 0, 0, 0, 0, 0);
  endtask

  task automatic sel(input int idx);
    cyc(0, 1, idx, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    coin_in = '0; sel_valid = 0; select_item = '0;
    cancel = 0; restock = 0; restock_item = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b1;

    // Buy item 1 with change
    coin(3); coin(3);
    sel(1);
    chk("tp1_item", dispense_item, 1);
    idle(1);
    chk("tp1_amt", change_amt, 2);
    idle(1);

    // Exact price, no change
    coin(3); coin(1); sel(1); idle(2);
    chk("tp2_ret", return_change, 0);

    // Over-credit then cancel
    coin(3); coin(3); coin(3); coin(3); coin(2);
    coin(2);
    chk("tp3_credit", credit, 14);
    cyc(0, 0, 0, 1, 0, 0);
    chk("tp3_refund", change_amt, 14);
    idle(1);

    // Exhaust item 0, then restock
    for (int k = 0; k < 3; k++) begin
      coin(3); sel(0); idle(1);
    end
    coin(3); sel(0);
    chk("tp4_soldout", sold_out, 1);
    cyc(0, 0, 0, 0, 1, 0);
    sel(0); idle(1);

    // Bad index, insufficient credit, coin with select
    sel(6);
    coin(2); sel(5);
    cyc(1, 1, 0, 0, 0, 0);
    chk("tp5_rej", coin_reject, 1);
    cyc(0, 0, 0, 1, 0, 0);
    idle(2);

    // Out-of-range restock is harmless; restock during decrement wins
    cyc(0, 0, 0, 0, 1, 7);
    coin(3); cyc(0, 1, 0, 0, 1, 0); idle(1);

    // Reset while dispensing
    coin(3); sel(0);
    #2 rst = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      coin(3); sel(0); idle(1);
    end
    coin(3); sel(0); cyc(0, 0, 0, 1, 0, 0); idle(1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0,
          ($urandom % 6) == 0, int'($urandom_range(0, 7)),
          ($urandom % 25) == 0, ($urandom % 20) == 0,
          int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
